// File: rtl/median_ctrl_pkg.sv
// Shared types and parameter checks for the median-filter window controller.
package median_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_t;

  function automatic bit win_is_legal(input int unsigned win);
    return (win >= 3) && (win <= 9) && ((win % 2) == 1);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order column/row counter; column wraps into row, row wraps at frame end.
module raster_counter #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       clear_i,
  input  logic                       advance_i,
  output logic [$clog2(IMG_W)-1:0]   col_o,
  output logic [$clog2(IMG_H)-1:0]   row_o,
  output logic                       last_o
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (advance_i) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/window_enable_controller.sv
// Tracks raster position of incoming pixels and flags when a full WIN x WIN window is available.
module window_enable_controller
  import median_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned WIN   = 9,
  localparam int unsigned CW   = $clog2(IMG_W),
  localparam int unsigned RW   = $clog2(IMG_H)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_pix_valid,
  output logic [1:0]    o_state,
  output logic          o_busy,
  output logic          o_win_en,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_frame_done
);

  if (!win_is_legal(WIN)) begin : g_bad_win
    $error("window_enable_controller: WIN must be odd and within 3..9");
  end
  if ((IMG_W < WIN) || (IMG_H < WIN)) begin : g_bad_img
    $error("window_enable_controller: image dimensions must be >= WIN");
  end

  localparam logic [CW-1:0] COL_WIN = CW'(WIN - 1);
  localparam logic [RW-1:0] ROW_WIN = RW'(WIN - 1);

  ctrl_state_t   state_q, state_d;
  logic          win_en_q, win_en_d;
  logic          accept;
  logic          clear;
  logic          last;
  logic          at_corner;
  logic          in_window;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  assign accept    = i_pix_valid && ((state_q == ST_FILL) || (state_q == ST_RUN));
  assign clear     = (state_q == ST_IDLE);
  assign at_corner = (row == ROW_WIN) && (col == COL_WIN);
  assign in_window = (row >= ROW_WIN) && (col >= COL_WIN);

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_raster (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .clear_i   (clear),
    .advance_i (accept),
    .col_o     (col),
    .row_o     (row),
    .last_o    (last)
  );

  // FILL checks frame end first so a WIN-sized image goes straight to DONE.
  always_comb begin
    state_d  = state_q;
    win_en_d = accept && in_window;
    unique case (state_q)
      ST_IDLE: if (i_start) state_d = ST_FILL;
      ST_FILL: begin
        if (accept && last)           state_d = ST_DONE;
        else if (accept && at_corner) state_d = ST_RUN;
      end
      ST_RUN:  if (accept && last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      win_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_en_q <= win_en_d;
    end
  end

  assign o_state      = state_q;
  assign o_busy       = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign o_win_en     = win_en_q;
  assign o_col        = col;
  assign o_row        = row;
  assign o_frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_window_enable_controller.sv
// Scoreboard bench: a behavioural model queues expected outputs per cycle; a 64x64 instance checks frame totals.
module tb_window_enable_controller;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned WN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, valid;
  logic [1:0] state;
  logic       busy, win_en, done;
  logic [1:0] col, row;

  logic       s2, v2;
  logic [1:0] d2_state;
  logic       d2_busy, d2_win, d2_done;
  logic [5:0] d2_col, d2_row;

  window_enable_controller #(.IMG_W(W), .IMG_H(H), .WIN(WN)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pix_valid(valid),
    .o_state(state), .o_busy(busy), .o_win_en(win_en),
    .o_col(col), .o_row(row), .o_frame_done(done)
  );

  window_enable_controller dut_dflt (
    .i_clk(clk), .i_rst(rst), .i_start(s2), .i_pix_valid(v2),
    .o_state(d2_state), .o_busy(d2_busy), .o_win_en(d2_win),
    .o_col(d2_col), .o_row(d2_row), .o_frame_done(d2_done)
  );

  typedef struct {
    int st; int busy; int win; int done; int col; int row;
  } exp_t;

  exp_t sb[$];
  int   m_state, m_col, m_row;
  int   n_checks = 0, n_pass = 0;
  int   win_cnt, done_cnt;
  int   d2_wcnt = 0, d2_dcnt = 0;

  always @(negedge clk) begin
    if (d2_win)  d2_wcnt++;
    if (d2_done) d2_dcnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_step(input bit s, input bit v);
    exp_t e;
    bit acc, last, corner;
    acc    = v && (m_state == 1 || m_state == 2);
    e.win  = (acc && m_row >= WN - 1 && m_col >= WN - 1) ? 1 : 0;
    last   = (m_col == W - 1) && (m_row == H - 1);
    corner = (m_col == WN - 1) && (m_row == WN - 1);
    case (m_state)
      0: if (s) begin m_state = 1; m_col = 0; m_row = 0; end
      1, 2: if (acc) begin
        if (m_col == W - 1) begin
          m_col = 0;
          m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else m_col++;
        if (last) m_state = 3;
        else if (m_state == 1 && corner) m_state = 2;
      end
      default: m_state = 0;
    endcase
    e.st   = m_state;
    e.busy = (m_state == 1 || m_state == 2) ? 1 : 0;
    e.done = (m_state == 3) ? 1 : 0;
    e.col  = m_col;
    e.row  = m_row;
    sb.push_back(e);
  endtask

  task automatic step(input bit s, input bit v);
    exp_t e;
    @(negedge clk);
    start = s;
    valid = v;
    model_step(s, v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("state", state, e.st);
    check("busy", busy, e.busy);
    check("win_en", win_en, e.win);
    check("frame_done", done, e.done);
    check("col", col, e.col);
    check("row", row, e.row);
    if (win_en === 1'b1) win_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; valid = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_win_en", win_en, 0);
    check("rst_done", done, 0);
    check("rst_col", col, 0);
    check("rst_row", row, 0);
    m_state = 0; m_col = 0; m_row = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, d0;
    rst = 1'b1; start = 1'b0; valid = 1'b0; s2 = 1'b0; v2 = 1'b0;
    m_state = 0; m_col = 0; m_row = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Frame A: 16 consecutive pixels
    win_cnt = 0; done_cnt = 0;
    step(1'b1, 1'b0);
    repeat (16) step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    check("A_win_count", win_cnt, 4);
    check("A_done_count", done_cnt, 1);

    // Frame B: valid every other cycle
    win_cnt = 0; done_cnt = 0;
    step(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
    check("B_win_count", win_cnt, 4);
    check("B_done_count", done_cnt, 1);

    // Frame C: reset after pixel 10, then pixels without a start
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b1);
    do_reset();
    win_cnt = 0; done_cnt = 0;
    repeat (6) step(1'b0, 1'b1);
    check("C_win_count", win_cnt, 0);
    check("C_done_count", done_cnt, 0);

    // Frame D: start with valid in IDLE, and a stray start during RUN
    win_cnt = 0; done_cnt = 0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(i == 12, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    check("D_win_count", win_cnt, 4);
    check("D_done_count", done_cnt, 1);

    // Default-parameter instance: two back-to-back 64x64 frames
    for (int f = 0; f < 2; f++) begin
      w0 = d2_wcnt;
      @(negedge clk); s2 = 1'b1;
      @(negedge clk); s2 = 1'b0; v2 = 1'b1;
      repeat (4096) @(negedge clk);
      v2 = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("dflt_win_count", d2_wcnt - w0, 3136);
      check("dflt_state_idle", d2_state, 0);
    end
    d0 = d2_dcnt;
    check("dflt_done_count", d0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/window_enable_controller.md
WINDOW_ENABLE_CONTROLLER -- requirements
Module: window_enable_controller

Interface
REQ-001 Parameter IMG_W, default 64: image width in pixels; SHALL be >= WIN.
REQ-002 Parameter IMG_H, default 64: image height in pixels; SHALL be >= WIN.
REQ-003 Parameter WIN, default 9: window side (odd, 3..9); elaboration SHALL fail on violation.
REQ-004 Derived constants CW = clog2(IMG_W) and RW = clog2(IMG_H) SHALL size the coordinate ports.
REQ-005 Port i_clk, input, 1: clock, rising edge.
REQ-006 Port i_rst, input, 1: reset, asynchronous, active-high.
REQ-007 Port i_start, input, 1: frame start pulse.
REQ-008 Port i_pix_valid, input, 1: one raster pixel written into the line buffer this cycle.
REQ-009 Port o_state, output, 2: current FSM state encoding.
REQ-010 Port o_busy, output, 1: high in FILL or RUN.
REQ-011 Port o_win_en, output, 1: window complete; median stage computes this cycle.
REQ-012 Port o_col, output, CW: column of the next pixel to be accepted.
REQ-013 Port o_row, output, RW: row of the next pixel to be accepted.
REQ-014 Port o_frame_done, output, 1: one-cycle end-of-frame pulse.

Function
REQ-015 States SHALL be IDLE=0, FILL=1, RUN=2, DONE=3.
REQ-016 IDLE: i_start -> FILL; col/row cleared to 0; i_pix_valid ignored.
REQ-017 FILL/RUN: on accepted pixel, col += 1; at col = IMG_W-1, col wraps to 0 and row += 1.
REQ-018 No i_pix_valid: col, row and state SHALL hold; o_win_en SHALL be 0 that following cycle.
REQ-019 FILL -> RUN on accepting pixel (row = WIN-1, col = WIN-1).
REQ-020 RUN -> DONE on accepting pixel (IMG_H-1, IMG_W-1); col/row return to 0.
REQ-021 DONE -> IDLE unconditionally after one cycle; o_frame_done = 1 only in DONE.
REQ-022 o_win_en SHALL be registered: high exactly one cycle after accepting a pixel with row >= WIN-1 and col >= WIN-1, otherwise low.
REQ-023 Per frame, o_win_en SHALL pulse exactly (IMG_H-WIN+1)*(IMG_W-WIN+1) times.
REQ-024 The final o_win_en of a frame SHALL coincide with the DONE cycle.
REQ-025 i_start SHALL be ignored outside IDLE.
REQ-026 i_start and i_pix_valid together in IDLE: only the state change occurs; the pixel is not counted.
REQ-027 Counters SHALL never exceed IMG_W-1 / IMG_H-1; no arithmetic overflow for any parameter set.

Reset
REQ-028 i_rst SHALL immediately force IDLE and col = row = 0, o_win_en = 0, o_frame_done = 0, o_busy = 0, o_state = 0.
REQ-029 Reset mid-frame SHALL abandon the frame: no further o_win_en or o_frame_done until a new i_start.
REQ-030 No initial blocks; reset is the only initialisation.

Structure
REQ-031 Package median_ctrl_pkg SHALL hold the state enum typedef and the WIN legality check function.
REQ-032 Sub-module raster_counter (parameters IMG_W/IMG_H; inputs clear/advance; outputs col, row, last) SHALL implement the wrap logic.

Verification (IMG_W=4, IMG_H=4, WIN=3 unless noted)
REQ-033 i_start then 16 consecutive valid pixels -> o_win_en pulses after pixels 11, 12, 15, 16 (4 total); o_frame_done one cycle after pixel 16.
REQ-034 Same stream with valid low every other cycle -> identical 4 pulses; o_col/o_row frozen on idle cycles.
REQ-035 i_rst asserted after pixel 10 -> state 0 and outputs 0 that cycle; a further 6 pixels without i_start -> no o_win_en.
REQ-036 i_start pulsed during RUN -> ignored; count stays 4 with exactly one o_frame_done.
REQ-037 Defaults (64x64, WIN=9), two back-to-back frames -> 3136 o_win_en per frame; 2 o_frame_done.
REQ-038 Illegal WIN=4 -> elaboration error.
